gfsk_demodulation: RTL and testbench
====================================

GFSK_DEMODULATION -- requirements
Module: gfsk_demodulation

Interface
REQ-001 Parameter SAMPLE_PER_SYMBOL, default 8: I/Q samples integrated per decided bit, range 2..16.
REQ-002 Parameter IQ_BIT_WIDTH, default 8: signed width of input I/Q.
REQ-003 Parameter ACC_BIT_WIDTH, default 2*IQ_BIT_WIDTH+5: signed width of the symbol accumulator.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-006 i_in  input  IQ_BIT_WIDTH signed  in-phase sample.
REQ-007 q_in  input  IQ_BIT_WIDTH signed  quadrature sample.
REQ-008 iq_valid  input  1  sample strobe; i_in/q_in are sampled only when high.
REQ-009 iq_valid_last  input  1  qualifies the final sample of a packet; ignored unless iq_valid is high.
REQ-010 phy_bit  output  1  decided bit.
REQ-011 bit_valid  output  1  one-cycle strobe qualifying phy_bit.
REQ-012 bit_valid_last  output  1  high with bit_valid on the final bit of a packet.

Function
REQ-013 The discriminator SHALL compute d = I[n-1]*Q[n] - Q[n-1]*I[n] at full width 2*IQ_BIT_WIDTH+1, signed, with no truncation.
REQ-014 Stage 1 (cycle t+1 for a sample accepted at t) SHALL register both products and store the current sample as previous; stage 2 (t+2) SHALL register d with its valid and last flags.
REQ-015 The previous-sample registers SHALL hold 0 after reset and after each last sample, so the first sample of every packet yields d = 0.
REQ-016 Stage 3 (t+3) SHALL add d into the accumulator, with sign-extension to ACC_BIT_WIDTH, and SHALL increment a 0..SAMPLE_PER_SYMBOL-1 sample counter.
REQ-017 When the counter reaches SAMPLE_PER_SYMBOL-1, or the sample carries last, the block SHALL emit a bit in the same cycle (t+3):
- phy_bit = 1 if (accumulator + d) > 0, else 0;
- bit_valid = 1;
- the accumulator and counter clear to 0.
REQ-018 A last sample SHALL close a partial symbol of any length 1..SAMPLE_PER_SYMBOL, assert bit_valid_last with bit_valid, and restart symbol alignment at the next valid sample.
REQ-019 Fixed latency: 3 cycles from acceptance of the symbol's closing sample to bit_valid.
REQ-020 Gaps in iq_valid SHALL stall the counter and accumulator without losing state; pipeline valids propagate one stage per clock.
REQ-021 Back-to-back packets (a last sample followed immediately by a valid sample) SHALL be processed with no dropped or merged bits.
REQ-022 Sign convention: a counter-clockwise rotation (positive frequency deviation) decodes as 1, matching the modulator mapping of 1 to positive deviation.
REQ-023 phy_bit SHALL hold its value between strobes; bit_valid and bit_valid_last are single-cycle pulses.

Reset
REQ-024 While rst=0 at a clock edge, the block SHALL clear:
- all pipeline registers, previous I/Q, accumulator and counter to 0;
- phy_bit, bit_valid and bit_valid_last to 0.
REQ-025 Reset asserted mid-symbol SHALL discard the partial symbol; no bit is emitted for it.
REQ-026 Samples presented while rst=0 SHALL be ignored; the first valid sample after release starts a new symbol.

Configuration
REQ-027 Macro GFSK_DEMOD_DISCRIM_OUT_EN.
- Defined: add output discrim_out (2*IQ_BIT_WIDTH+1 signed) and output discrim_out_valid (1), both driven from stage 2 and reset to 0.
- Undefined: these ports and their logic SHALL be absent; all other behaviour is identical in both cases.

Verification
REQ-028 Constant +pi/4 per-sample rotation, amplitude 100, 16 samples, last on the 16th -> bits 1,1; bit_valid_last on the second; each bit at t+3 of its closing sample.
REQ-029 Constant -pi/4 rotation, 8 samples, last on the 8th -> single bit 0 with bit_valid_last.
REQ-030 Modulator output for bits 1,0,1,1,0 looped directly in (default parameters, phase-aligned) -> phy_bit sequence 1,0,1,1,0 with last on the fifth.
REQ-031 +pi/4 rotation with iq_valid low every other cycle, 8 samples -> one bit 1 with latency measured from the 8th valid sample, no extra bits.
REQ-032 rst=0 pulsed after 5 samples of a symbol, then 8 fresh +pi/4 samples with last -> no bit for the aborted symbol; exactly one bit 1 follows.
REQ-033 Last asserted on the 3rd sample of a symbol (+pi/4) -> bit 1 with bit_valid_last 3 cycles later; the next sample starts at counter 0 and has d = 0.

Source files
------------

// File: rtl/gfsk_demodulation.sv
// GFSK demodulator: a cross-product frequency discriminator feeds an integrate-and-dump bit slicer.
// Optional macro GFSK_DEMOD_DISCRIM_OUT_EN exposes the stage-2 discriminator value and its strobe.
module gfsk_demodulation #(
    parameter int SAMPLE_PER_SYMBOL = 8,
    parameter int IQ_BIT_WIDTH      = 8,
    parameter int ACC_BIT_WIDTH     = 2*IQ_BIT_WIDTH+5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [IQ_BIT_WIDTH-1:0] i_in,
    input  logic signed [IQ_BIT_WIDTH-1:0] q_in,
    input  logic                           iq_valid,
    input  logic                           iq_valid_last,
    output logic                           phy_bit,
    output logic                           bit_valid,
    output logic                           bit_valid_last
`ifdef GFSK_DEMOD_DISCRIM_OUT_EN
    ,
    output logic signed [2*IQ_BIT_WIDTH:0] discrim_out,
    output logic                           discrim_out_valid
`endif
);

    localparam int PW    = 2*IQ_BIT_WIDTH;
    localparam int DW    = PW+1;
    localparam int CNT_W = $clog2(SAMPLE_PER_SYMBOL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PER_SYMBOL-1);

    logic signed [IQ_BIT_WIDTH-1:0]  prev_i_reg, prev_q_reg;
    logic signed [PW-1:0]            prod_a_reg, prod_b_reg;
    logic                            s1_valid_reg, s1_last_reg;
    logic signed [DW-1:0]            d_reg;
    logic                            s2_valid_reg, s2_last_reg;
    logic signed [ACC_BIT_WIDTH-1:0] acc_reg;
    logic        [CNT_W-1:0]         cnt_reg;
    logic                            phy_bit_reg, bit_valid_reg, bit_last_reg;

    logic signed [ACC_BIT_WIDTH-1:0] acc_sum;
    logic                            close_sym;

    // Stage 1: cross products against the previous sample; a last sample zeroes
    // the history so the next packet's first discriminator output is 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_i_reg   <= '0;
            prev_q_reg   <= '0;
            prod_a_reg   <= '0;
            prod_b_reg   <= '0;
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
        end else begin
            s1_valid_reg <= iq_valid;
            s1_last_reg  <= iq_valid & iq_valid_last;
            if (iq_valid) begin
                prod_a_reg <= PW'(prev_i_reg) * PW'(q_in);
                prod_b_reg <= PW'(prev_q_reg) * PW'(i_in);
                prev_i_reg <= iq_valid_last ? '0 : i_in;
                prev_q_reg <= iq_valid_last ? '0 : q_in;
            end
        end
    end

    // Stage 2: full-width difference, positive for counter-clockwise rotation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            d_reg        <= '0;
            s2_valid_reg <= 1'b0;
            s2_last_reg  <= 1'b0;
        end else begin
            s2_valid_reg <= s1_valid_reg;
            s2_last_reg  <= s1_last_reg;
            if (s1_valid_reg) begin
                d_reg <= DW'(prod_a_reg) - DW'(prod_b_reg);
            end
        end
    end

    always_comb begin
        acc_sum   = acc_reg + ACC_BIT_WIDTH'(d_reg);
        close_sym = s2_valid_reg & (s2_last_reg | (cnt_reg == CNT_LAST));
    end

    // Stage 3: integrate and dump; the decision uses the sum including this d.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_reg       <= '0;
            cnt_reg       <= '0;
            phy_bit_reg   <= 1'b0;
            bit_valid_reg <= 1'b0;
            bit_last_reg  <= 1'b0;
        end else begin
            bit_valid_reg <= close_sym;
            bit_last_reg  <= close_sym & s2_last_reg;
            if (s2_valid_reg) begin
                if (close_sym) begin
                    acc_reg     <= '0;
                    cnt_reg     <= '0;
                    phy_bit_reg <= ~acc_sum[ACC_BIT_WIDTH-1] & (|acc_sum);
                end else begin
                    acc_reg <= acc_sum;
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

    assign phy_bit        = phy_bit_reg;
    assign bit_valid      = bit_valid_reg;
    assign bit_valid_last = bit_last_reg;

`ifdef GFSK_DEMOD_DISCRIM_OUT_EN
    assign discrim_out       = d_reg;
    assign discrim_out_valid = s2_valid_reg;
`endif

endmodule

// File: tb/tb_gfsk_demodulation.sv
// Table-driven bench for gfsk_demodulation: packets of rotating I/Q, expected bits from the table,
// checked for value, last flag and arrival cycle; plus reset, abort and hold sequences.
module tb_gfsk_demodulation;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic signed [7:0] i_in = '0;
    logic signed [7:0] q_in = '0;
    logic              iq_valid = 1'b0;
    logic              iq_valid_last = 1'b0;
    logic              phy_bit, bit_valid, bit_valid_last;

    gfsk_demodulation dut (
        .clk            (clk),
        .rst            (rst),
        .i_in           (i_in),
        .q_in           (q_in),
        .iq_valid       (iq_valid),
        .iq_valid_last  (iq_valid_last),
        .phy_bit        (phy_bit),
        .bit_valid      (bit_valid),
        .bit_valid_last (bit_valid_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Phase index p in units of pi/4, amplitude 100.
    logic signed [7:0] cos_t [8] = '{8'sd100, 8'sd71, 8'sd0, -8'sd71, -8'sd100, -8'sd71, 8'sd0, 8'sd71};
    logic signed [7:0] sin_t [8] = '{8'sd0, 8'sd71, 8'sd100, 8'sd71, 8'sd0, -8'sd71, -8'sd100, -8'sd71};

    // pat[j]=1: samples of 8-sample group j rotate +pi/4, else -pi/4; bits[j]: expected j-th bit.
    typedef struct {
        int         nsamp;
        logic [7:0] pat;
        bit         gap;
        int         start;
        int         nbits;
        logic [7:0] bits;
    } scen_t;

    typedef struct {
        logic b;
        logic l;
        int   cyc;
    } exp_t;

    scen_t scen [6];
    exp_t  expq [$];
    int    n_vec = 0;
    int    n_err = 0;
    int    n_strobe = 0;

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end else begin
            $display("ok   %s: %0d", name, got);
        end
    endtask

    // Monitor: every strobe must match the head of the expected queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bit_valid === 1'b1) begin
                if (expq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL extra_bit at cycle %0d: got phy_bit=%0b, want no strobe", cyc, phy_bit);
                end else begin
                    e = expq.pop_front();
                    check($sformatf("bit%0d_value", n_strobe), int'(phy_bit), int'(e.b));
                    check($sformatf("bit%0d_last", n_strobe), int'(bit_valid_last), int'(e.l));
                    check($sformatf("bit%0d_cycle", n_strobe), cyc, e.cyc);
                end
                n_strobe++;
            end else if (bit_valid_last === 1'b1) begin
                n_vec++;
                n_err++;
                $display("FAIL stray_last at cycle %0d: got bit_valid_last=1, want 0", cyc);
            end
        end
    end

    task automatic send_packet(input scen_t s);
        int ph;
        int sc;
        int bidx;
        exp_t e;
        ph = s.start;
        sc = 0;
        bidx = 0;
        for (int k = 0; k < s.nsamp; k++) begin
            if (k > 0) ph = (ph + (s.pat[k/8] ? 1 : 7)) % 8;
            if (s.gap && k > 0) begin
                iq_valid = 1'b0;
                iq_valid_last = 1'b0;
                @(posedge clk); #1;
            end
            i_in = cos_t[ph];
            q_in = sin_t[ph];
            iq_valid = 1'b1;
            iq_valid_last = (k == s.nsamp-1);
            if (sc == 7 || k == s.nsamp-1) begin
                e.b = s.bits[bidx];
                e.l = (k == s.nsamp-1);
                e.cyc = cyc + 3;
                expq.push_back(e);
                bidx++;
                sc = 0;
            end else begin
                sc++;
            end
            @(posedge clk); #1;
        end
        iq_valid = 1'b0;
        iq_valid_last = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 60 && expq.size() != 0; c++) @(posedge clk);
        n_vec++;
        if (expq.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d bits outstanding, want 0", expq.size());
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        //             nsamp  pat    gap   start nbits bits
        scen[0] = '{16, 8'h03, 1'b0, 0, 2, 8'h03};   // +pi/4, two full symbols
        scen[1] = '{8,  8'h00, 1'b0, 0, 1, 8'h00};   // -pi/4, one symbol
        scen[2] = '{40, 8'h0D, 1'b0, 0, 5, 8'h0D};   // modulated 1,0,1,1,0
        scen[3] = '{8,  8'h01, 1'b1, 0, 1, 8'h01};   // valid gaps
        scen[4] = '{3,  8'h01, 1'b0, 0, 1, 8'h01};   // short last
        scen[5] = '{1,  8'h00, 1'b0, 4, 1, 8'h00};   // one sample: d must be 0

        // Reset with valid samples presented: they must be ignored.
        rst = 1'b0;
        iq_valid = 1'b1;
        i_in = 8'sd100;
        q_in = 8'sd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_phy_bit", int'(phy_bit), 0);
        check("reset_bit_valid", int'(bit_valid), 0);
        check("reset_bit_valid_last", int'(bit_valid_last), 0);
        iq_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;

        // All table packets back to back.
        for (int v = 0; v < 6; v++) send_packet(scen[v]);
        drain();

        // Abort a symbol with reset after 5 samples.
        for (int k = 0; k < 5; k++) begin
            i_in = cos_t[k];
            q_in = sin_t[k];
            iq_valid = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("abort_bit_valid", int'(bit_valid), 0);
        check("abort_phy_bit", int'(phy_bit), 0);
        @(posedge clk); #1;
        iq_valid = 1'b0;
        rst = 1'b1;
        send_packet('{8, 8'h01, 1'b0, 0, 1, 8'h01});
        drain();

        // Decision must hold between strobes.
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("phy_bit_hold", int'(phy_bit), 1);
        check("total_strobes", n_strobe, 12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
